// File: rtl/dm_responder_if.sv
// Load/store handshake between the M stage (master) and the data memory (slave).
interface dm_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, be, wdata, pc,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, be, wdata, pc,
    output ready, rvalid, rdata, err
  );
endinterface

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder with programmable latency and one-cycle rvalid pulse.
// Optional store trace enabled by defining DM_WRITE_LOG_EN.
module dm_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input logic          clk,
  input logic          reset,
  dm_responder_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_pc;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_in_range;
  logic [31:0]           w_merged;
  logic                  w_unused;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign w_idx      = r_addr[ADDR_WIDTH+1:2];
  assign w_in_range = (r_addr[31:ADDR_WIDTH+2] == {(30-ADDR_WIDTH){1'b0}});
  assign w_merged   = lane_merge(r_mem[w_idx], r_wdata, r_be);
  assign w_unused   = &{1'b0, r_addr[1:0], r_pc};

  assign bus.ready  = (r_state != S_BUSY);
  assign bus.rvalid = r_rvalid;
  assign bus.rdata  = r_rdata;
  assign bus.err    = r_err;

  // Request FSM, latency counter, memory array and registered response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_we     <= 1'b0;
      r_addr   <= 32'd0;
      r_be     <= 4'd0;
      r_wdata  <= 32'd0;
      r_pc     <= 32'd0;
      r_rvalid <= 1'b0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else begin
      case (r_state)
        S_IDLE, S_RESP: begin
          r_rvalid <= 1'b0;
          if (bus.req) begin
            r_we    <= bus.we;
            r_addr  <= bus.addr;
            r_be    <= bus.be;
            r_wdata <= bus.wdata;
            r_pc    <= bus.pc;
            r_cnt   <= 4'(LATENCY - 1);
            r_state <= S_BUSY;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rvalid <= 1'b1;
            r_state  <= S_RESP;
            // Out-of-range requests never touch the array.
            if (!w_in_range) begin
              r_rdata <= 32'd0;
              r_err   <= 1'b1;
            end else if (r_we) begin
              r_mem[w_idx] <= w_merged;
              r_rdata      <= w_merged;
              r_err        <= 1'b0;
`ifdef DM_WRITE_LOG_EN
              $display("@%h: *%h <= %h", r_pc, {r_addr[31:2], 2'b00}, w_merged);
`endif
            end else begin
              r_rdata <= r_mem[w_idx];
              r_err   <= 1'b0;
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_rvalid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder (ADDR_WIDTH=10, LATENCY=2).
module tb_dm_responder;
  localparam int LAT = 2;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_mis;

  dm_responder_if bus ();

  dm_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request from an aligned point (#1 after a rising edge) and wait for its response.
  task automatic xfer(input string tag, input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err);
    int k;
    check_val({tag, "_rdy_pre"}, {31'd0, bus.ready}, 32'd1);
    bus.req = 1'b1; bus.we = we; bus.addr = addr; bus.be = be;
    bus.wdata = wdata; bus.pc = 32'h0000_0400 + addr;
    @(posedge clk); #1;
    bus.req = 1'b0;
    check_val({tag, "_rdy_busy"}, {31'd0, bus.ready}, 32'd0);
    k = 0;
    while (!bus.rvalid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check_val({tag, "_lat"}, k, LAT);
    check_val({tag, "_rdata"}, bus.rdata, exp_rd);
    check_val({tag, "_err"}, {31'd0, bus.err}, {31'd0, exp_err});
    @(posedge clk); #1;
    check_val({tag, "_rv_drop"}, {31'd0, bus.rvalid}, 32'd0);
    check_val({tag, "_hold"}, bus.rdata, exp_rd);
  endtask

  initial begin
    int k;
    n_cmp = 0; n_mis = 0;
    reset = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = 32'd0; bus.be = 4'd0;
    bus.wdata = 32'd0; bus.pc = 32'd0;
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;
    check_val("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    check_val("rst_rdata", bus.rdata, 32'd0);
    check_val("rst_err", {31'd0, bus.err}, 32'd0);
    check_val("rst_ready", {31'd0, bus.ready}, 32'd1);

    xfer("ld0",      1'b0, 32'h0000_0000, 4'b0000, 32'h0,         32'h0000_0000, 1'b0);
    xfer("st_full",  1'b1, 32'h0000_0010, 4'b1111, 32'h1234_5678, 32'h1234_5678, 1'b0);
    xfer("ld_full",  1'b0, 32'h0000_0010, 4'b0000, 32'h0,         32'h1234_5678, 1'b0);
    xfer("st_part",  1'b1, 32'h0000_0010, 4'b0101, 32'hAABB_CCDD, 32'h12BB_56DD, 1'b0);
    xfer("ld_part",  1'b0, 32'h0000_0013, 4'b0000, 32'h0,         32'h12BB_56DD, 1'b0);
    xfer("ld_oor",   1'b0, 32'h0000_1000, 4'b0000, 32'h0,         32'h0000_0000, 1'b1);
    xfer("st_oor",   1'b1, 32'h0000_1010, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1);
    xfer("ld_after", 1'b0, 32'h0000_0010, 4'b0000, 32'h0,         32'h12BB_56DD, 1'b0);
    xfer("st_be0",   1'b1, 32'h0000_0010, 4'b0000, 32'hFFFF_FFFF, 32'h12BB_56DD, 1'b0);
    xfer("ld_be0",   1'b0, 32'h0000_0010, 4'b0000, 32'h0,         32'h12BB_56DD, 1'b0);

    // Back-to-back: load held on req during the store's RESP cycle.
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h0000_0020; bus.be = 4'b1111;
    bus.wdata = 32'hCAFE_F00D; bus.pc = 32'h0000_0500;
    @(posedge clk); #1;
    bus.req = 1'b0;
    k = 0;
    while (!bus.rvalid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check_val("b2b_st_lat", k, LAT);
    check_val("b2b_st_rdata", bus.rdata, 32'hCAFE_F00D);
    check_val("b2b_resp_ready", {31'd0, bus.ready}, 32'd1);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h0000_0020; bus.be = 4'b0000;
    @(posedge clk); #1;
    bus.req = 1'b0;
    check_val("b2b_rv_drop", {31'd0, bus.rvalid}, 32'd0);
    check_val("b2b_accepted", {31'd0, bus.ready}, 32'd0);
    k = 1;
    while (!bus.rvalid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check_val("b2b_spacing", k, LAT + 1);
    check_val("b2b_ld_rdata", bus.rdata, 32'hCAFE_F00D);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("b2b_hold", bus.rdata, 32'hCAFE_F00D);

    // Reset while a store is in flight.
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h0000_0004; bus.be = 4'b1111;
    bus.wdata = 32'hFFFF_FFFF; bus.pc = 32'h0000_0600;
    @(posedge clk); #1;
    bus.req = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_val("abort_rvalid", {31'd0, bus.rvalid}, 32'd0);
    check_val("abort_rdata", bus.rdata, 32'd0);
    check_val("abort_err", {31'd0, bus.err}, 32'd0);
    check_val("abort_ready", {31'd0, bus.ready}, 32'd1);
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    xfer("ld_abort", 1'b0, 32'h0000_0004, 4'b0000, 32'h0, 32'h0000_0000, 1'b0);
    xfer("ld_clr",   1'b0, 32'h0000_0020, 4'b0000, 32'h0, 32'h0000_0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Multi-cycle data-memory responder: the memory end of the pipeline's M-stage load/store interface.
- Accepts one load/store request at a time through a req/ready handshake and performs it after a programmable latency.
- Returns the read data with a one-cycle rvalid pulse.
- Supersedes single-cycle DM behaviour, so the M stage can be exercised against a memory that stalls the pipeline.

Parameters:
- ADDR_WIDTH, 10, word-address bits; depth = 2^ADDR_WIDTH words of 32 bits.
- LATENCY, 2, clock edges from request acceptance to the rvalid rising edge; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  request valid from the M stage.
- we  input  1  1 = store, 0 = load; sampled on acceptance.
- addr  input  32  byte address; bits [1:0] ignored; word index = addr[ADDR_WIDTH+1:2].
- be  input  4  byte-lane enables for stores; be[i] selects bits [8i+7:8i]; ignored for loads.
- wdata  input  32  store data, already lane-aligned.
- pc  input  32  PC of the requesting instruction; used only for the write log.
- ready  output  1  request can be accepted this cycle.
- rvalid  output  1  one-cycle pulse: response is valid.
- rdata  output  32  response word.
- err  output  1  qualifies rvalid: address out of range.

Behaviour:
- States: IDLE, BUSY, RESP. ready = (state != BUSY), combinational.
- Reset (async, any time): state IDLE, cnt 0, rvalid 0, rdata 0, err 0, all memory words 0.
  - Any pending request is aborted and no write occurs.
- Acceptance: req && ready at a rising edge.
  - Latch we, addr, be, wdata, pc.
  - cnt <= LATENCY-1; state <= BUSY.
- BUSY, cnt != 0: cnt <= cnt-1. Inputs are ignored.
- BUSY, cnt == 0: perform the operation, set rvalid <= 1, state <= RESP.
  - Load: rdata <= mem[idx].
  - Store: update only the lanes with be[i]=1. rdata <= resulting (new) word.
  - Store with be = 0000: no change, rdata = current word.
- Range check: out of range if latched addr[31:ADDR_WIDTH+2] != 0.
  - Then: no memory access, rdata <= 0, err <= 1.
  - Otherwise err <= 0.
- RESP (exactly one cycle): rvalid, rdata and err are visible.
  - If req: accept the new request (back-to-back); rvalid <= 0.
  - Else state <= IDLE; rvalid <= 0.
  - rdata and err hold their value until the next response.
- Timing:
  - Accept at edge 0 → rvalid high after edge LATENCY, low after edge LATENCY+1.
  - Minimum request period is LATENCY+1 cycles.
- Read-after-write: a load issued in the RESP cycle of a store to the same word returns the new value.
- req deasserted while BUSY has no effect; the request completes.
- M-stage stall: the pipeline holds while (req && !ready) or (req outstanding && !rvalid). That condition is generated outside this block.

Optional Feature:
- Macro: DM_WRITE_LOG_EN.
- Defined: every in-range store performed issues a $display at the operation edge, formatted "@%h: *%h <= %h".
  - Fields: latched pc, the word-aligned byte address {addr[31:2],2'b00}, and the resulting 32-bit word.
  - No output for loads, out-of-range stores, or aborted requests.
- Undefined: no simulation output. Functional behaviour is identical.

Test Plan:
- Reset, then load from addr 0x00000000 with LATENCY=2 → ready low for 2 cycles, rvalid pulse 2 edges after accept, rdata=0x00000000, err=0.
- Store 0x12345678 to 0x00000010 with be=1111, then load 0x00000010 → rdata=0x12345678. With DM_WRITE_LOG_EN, log line "@<pc>: *00000010 <= 12345678".
- Store 0xAABBCCDD to 0x00000010 with be=0101, over 0x12345678 → response and later load both return 0x12BB56DD.
- Load from addr 0x00001000 with ADDR_WIDTH=10 → rvalid=1, err=1, rdata=0; memory unchanged.
- Store issued, then a load to the same word held on req during RESP → load accepted in the RESP cycle, rvalid pulses spaced LATENCY+1 cycles apart, load returns the stored value.
- Assert reset while BUSY on a store of 0xFFFFFFFF to 0x00000004 → outputs 0 immediately, state IDLE, later load of 0x00000004 returns 0, no log line.
